// File: rtl/exe_muldiv.sv
// EXE-stage multiply/divide unit: single-cycle MULT/MULTU and a restoring DIV/DIVU.
// Holds the pipeline through a stall while busy; the {hi, lo} result feeds the HI/LO write path.
module exe_muldiv #(
    parameter int DATA_W    = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              exe_i_md_start,
    input  logic [1:0]        exe_i_md_op,
    input  logic [DATA_W-1:0] exe_i_src1,
    input  logic [DATA_W-1:0] exe_i_src2,
    input  logic              exe_i_flush,
    output logic              exe_o_md_stall,
    output logic              exe_o_md_done,
    output logic [DATA_W-1:0] exe_o_hi,
    output logic [DATA_W-1:0] exe_o_lo
);

    localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   op_a_reg;     // multiplicand, or dividend shifting into quotient
    logic [DATA_W-1:0]   op_b_reg;     // multiplier or divisor
    logic [DATA_W-1:0]   rem_reg;
    logic                sign_reg;     // product / quotient sign
    logic                rsign_reg;    // remainder sign follows the dividend
    logic                done_reg;
    logic [DATA_W-1:0]   hi_reg;
    logic [DATA_W-1:0]   lo_reg;

    logic                src1_neg;
    logic                src2_neg;
    logic [DATA_W-1:0]   src1_mag;
    logic [DATA_W-1:0]   src2_mag;
    logic [2*DATA_W-1:0] prod_mag;
    logic [2*DATA_W-1:0] prod_res;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_sub;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                last_step;

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign src1_neg = exe_i_src1[DATA_W-1] & ~exe_i_md_op[0];
    assign src2_neg = exe_i_src2[DATA_W-1] & ~exe_i_md_op[0];
    assign src1_mag = src1_neg ? -exe_i_src1 : exe_i_src1;
    assign src2_mag = src2_neg ? -exe_i_src2 : exe_i_src2;

    assign prod_mag = {{DATA_W{1'b0}}, op_a_reg} * {{DATA_W{1'b0}}, op_b_reg};
    assign prod_res = sign_reg ? -prod_mag : prod_mag;

    // The shifted remainder is kept one bit wider so divisors above 2^(W-1) still compare correctly
    assign rem_shift = {rem_reg, op_a_reg[DATA_W-1]};
    assign rem_sub   = rem_shift - {1'b0, op_b_reg};
    assign q_bit     = ~rem_sub[DATA_W];
    assign rem_next  = q_bit ? rem_sub[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    assign quo_next  = {op_a_reg[DATA_W-2:0], q_bit};
    assign quo_fix   = sign_reg  ? -quo_next : quo_next;
    assign rem_fix   = rsign_reg ? -rem_next : rem_next;
    assign last_step = (cnt_reg == CNT_W'(DIV_ITERS - 1));

    assign exe_o_md_stall = cpu_rst_n &
                            (((state_reg == IDLE) & exe_i_md_start & ~exe_i_flush) |
                             (state_reg == MUL) | (state_reg == DIV));
    assign exe_o_md_done  = done_reg;
    assign exe_o_hi       = hi_reg;
    assign exe_o_lo       = lo_reg;

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            rem_reg   <= '0;
            sign_reg  <= 1'b0;
            rsign_reg <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            if (exe_i_flush) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (exe_i_md_start) begin
                            if (!exe_i_md_op[1]) begin
                                op_a_reg  <= src1_mag;
                                op_b_reg  <= src2_mag;
                                sign_reg  <= src1_neg ^ src2_neg;
                                state_reg <= MUL;
                            end else if (exe_i_src2 == '0) begin
                                // divide by zero short-circuits with a fixed result
                                hi_reg    <= exe_i_src1;
                                lo_reg    <= '1;
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                op_a_reg  <= src1_mag;
                                op_b_reg  <= src2_mag;
                                sign_reg  <= src1_neg ^ src2_neg;
                                rsign_reg <= src1_neg;
                                cnt_reg   <= '0;
                                rem_reg   <= '0;
                                state_reg <= DIV;
                            end
                        end
                    end
                    MUL: begin
                        {hi_reg, lo_reg} <= prod_res;
                        done_reg         <= 1'b1;
                        state_reg        <= DONE;
                    end
                    DIV: begin
                        op_a_reg <= quo_next;
                        rem_reg  <= rem_next;
                        cnt_reg  <= cnt_reg + 1'b1;
                        if (last_step) begin
                            hi_reg    <= rem_fix;
                            lo_reg    <= quo_fix;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
